// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver with input
// synchronisation, false-start rejection, 3-sample majority vote,
// parity/framing/overrun flags and a valid/ack handshake to the consumer.
// Optional feature macro: UART_RX_BREAK_DETECT_EN (line-break detection
// with a BREAK recovery state). Without it a break is delivered as a
// zero word with framingError set, and breakDetected is held 0.
module uart_rx_param #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 1,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic                 baudOut,
  input  logic                 rst,
  input  logic                 serialInput,
  input  logic                 rxAck,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 parityError,
  output logic                 framingError,
  output logic                 rxValid,
  output logic                 overrun,
  output logic                 breakDetected
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
`ifdef UART_RX_BREAK_DETECT_EN
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
`else
    S_STOP   = 3'd4
`endif
  } state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [IDX_W-1:0]     bit_idx, idx_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 par_acc, par_d;
  logic                 fe_acc, fe_d;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                 zero_run, zero_d;
`endif

  logic                 sync1, sync2;
  logic [2:0]           hist;

  logic [DATA_BITS-1:0] data_d;
  logic                 perr_d, ferr_d, valid_d, ovr_d, brk_d;

  logic                 sample_c, fall_c, stop_fe_c, par_err_c, commit_c;

  // Two-flop synchroniser followed by a 3-deep history for the majority vote
  always_ff @(posedge baudOut) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 3'b111;
    end else begin
      sync1 <= serialInput;
      sync2 <= sync1;
      hist  <= {hist[1:0], sync2};
    end
  end

  // Majority of the history is the bit value; edge detect on the synchronised line
  assign sample_c = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign fall_c   = hist[0] & ~sync2;

  // Framing status including the stop bit currently being sampled
  assign stop_fe_c = fe_acc | ~sample_c;

  // Parity verdict from the running XOR of data and parity bits
  always_comb begin
    if (PARITY_MODE == 1) begin
      par_err_c = par_acc;
    end else if (PARITY_MODE == 2) begin
      par_err_c = ~par_acc;
    end else begin
      par_err_c = 1'b0;
    end
  end

  // Frame sequencing, commit and consumer handshake
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = bit_idx;
    shreg_d  = shreg;
    par_d    = par_acc;
    fe_d     = fe_acc;
`ifdef UART_RX_BREAK_DETECT_EN
    zero_d   = zero_run;
`endif
    data_d   = dataOut;
    perr_d   = parityError;
    ferr_d   = framingError;
    valid_d  = rxValid;
    ovr_d    = overrun;
    brk_d    = 1'b0;
    commit_c = 1'b0;

    case (state)
      S_IDLE: begin
        if (fall_c) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_d = '0;
          if (sample_c) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
            par_d   = 1'b0;
            fe_d    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_d  = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_d   = '0;
          shreg_d = {sample_c, shreg[DATA_BITS-1:1]};
          par_d   = par_acc ^ sample_c;
`ifdef UART_RX_BREAK_DETECT_EN
          zero_d  = zero_run & ~sample_c;
`endif
          if (bit_idx == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY_MODE == 0) ? S_STOP : S_PARITY;
          end else begin
            idx_d = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (cnt == FULL_LAST) begin
          cnt_d   = '0;
          par_d   = par_acc ^ sample_c;
`ifdef UART_RX_BREAK_DETECT_EN
          zero_d  = zero_run & ~sample_c;
`endif
          idx_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_d = '0;
          fe_d  = stop_fe_c;
`ifdef UART_RX_BREAK_DETECT_EN
          if ((bit_idx == '0) && zero_run && !sample_c) begin
            brk_d   = 1'b1;
            idx_d   = '0;
            state_d = S_BREAK;
          end else
`endif
          if (bit_idx == LAST_STOP) begin
            commit_c = 1'b1;
            idx_d    = '0;
            state_d  = S_IDLE;
          end else begin
            idx_d = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

`ifdef UART_RX_BREAK_DETECT_EN
      // Wait for the line to sit idle for a full bit time before rearming
      S_BREAK: begin
        if (sync2) begin
          if (cnt == FULL_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (commit_c) begin
      if (!rxValid || rxAck) begin
        data_d  = shreg;
        perr_d  = par_err_c;
        ferr_d  = stop_fe_c;
        valid_d = 1'b1;
        if (rxValid) begin
          ovr_d = 1'b0;
        end
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rxAck && rxValid) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge baudOut) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      par_acc       <= 1'b0;
      fe_acc        <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      zero_run      <= 1'b0;
`endif
      dataOut       <= '0;
      parityError   <= 1'b0;
      framingError  <= 1'b0;
      rxValid       <= 1'b0;
      overrun       <= 1'b0;
      breakDetected <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      bit_idx       <= idx_d;
      shreg         <= shreg_d;
      par_acc       <= par_d;
      fe_acc        <= fe_d;
`ifdef UART_RX_BREAK_DETECT_EN
      zero_run      <= zero_d;
`endif
      dataOut       <= data_d;
      parityError   <= perr_d;
      framingError  <= ferr_d;
      rxValid       <= valid_d;
      overrun       <= ovr_d;
      breakDetected <= brk_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param. Instance u0 uses the
// reference configuration (8 data, even parity, 1 stop, x16); u1 uses
// 7 data, odd parity, 2 stops, x8. Serial lines change on the falling edge,
// outputs are checked on the falling edge.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ser0, ack0, pe0, fe0, v0, ov0, brk0;
  logic [7:0] dout0;
  logic       ser1, ack1, pe1, fe1, v1, ov1, brk1;
  logic [6:0] dout1;

  int n_cmp = 0;
  int n_err = 0;
  int n_brk0 = 0;

  uart_rx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16)) u0 (
    .baudOut(clk), .rst(rst), .serialInput(ser0), .rxAck(ack0),
    .dataOut(dout0), .parityError(pe0), .framingError(fe0),
    .rxValid(v0), .overrun(ov0), .breakDetected(brk0)
  );

  uart_rx_param #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(8)) u1 (
    .baudOut(clk), .rst(rst), .serialInput(ser1), .rxAck(ack1),
    .dataOut(dout1), .parityError(pe1), .framingError(fe1),
    .rxValid(v1), .overrun(ov1), .breakDetected(brk1)
  );

  // Count break pulses seen on the reference instance
  always @(posedge clk) begin
    if (brk0 === 1'b1) n_brk0 <= n_brk0 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame bits LSB first: start, data, optional parity, two stop slots
  function automatic logic [15:0] mkf(input logic [8:0] d, input int db, input int np,
                                      input logic p, input logic s0, input logic s1);
    logic [15:0] f;
    int idx;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) f[1 + i] = d[i];
    idx = 1 + db;
    if (np != 0) begin
      f[idx] = p;
      idx++;
    end
    f[idx] = s0;
    f[idx + 1] = s1;
    return f;
  endfunction

  // Drive nb bits of os ticks each; optional ack/reset pulse at tick index;
  // from tick trunc onwards the line is held idle. Entered on a falling edge.
  task automatic send(input int inst, input logic [15:0] f, input int nb, input int os,
                      input int ack_at, input int rst_at, input int trunc);
    logic b;
    for (int t = 0; t < nb * os; t++) begin
      b = (t < trunc) ? f[t / os] : 1'b1;
      if (inst == 0) begin
        ser0 = b;
        ack0 = (t == ack_at);
      end else begin
        ser1 = b;
        ack1 = (t == ack_at);
      end
      rst = (t == rst_at);
      @(negedge clk);
    end
    ser0 = 1'b1;
    ser1 = 1'b1;
    ack0 = 1'b0;
    ack1 = 1'b0;
    rst  = 1'b0;
  endtask

  task automatic ack_pulse(input int inst);
    if (inst == 0) ack0 = 1'b1; else ack1 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    ack1 = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    ser0 = 1'b1;
    ser1 = 1'b1;
    ack0 = 1'b0;
    ack1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_data",  32'(dout0), 32'h0);
    chk("rst_valid", 32'(v0),    32'h0);
    chk("rst_perr",  32'(pe0),   32'h0);
    chk("rst_ferr",  32'(fe0),   32'h0);
    chk("rst_ovr",   32'(ov0),   32'h0);
    chk("rst_brk",   32'(brk0),  32'h0);
    chk("rst_valid1", 32'(v1),   32'h0);

    // Clean frame 0xA5, then acknowledge
    send(0, mkf(9'h0A5, 8, 1, 1'b0, 1'b1, 1'b1), 11, 16, -1, -1, 9999);
    chk("a5_data",  32'(dout0), 32'hA5);
    chk("a5_perr",  32'(pe0),   32'h0);
    chk("a5_ferr",  32'(fe0),   32'h0);
    chk("a5_valid", 32'(v0),    32'h1);
    ack_pulse(0);
    chk("a5_ack_valid", 32'(v0), 32'h0);

    // Parity error on 0x3C
    send(0, mkf(9'h03C, 8, 1, 1'b1, 1'b1, 1'b1), 11, 16, -1, -1, 9999);
    chk("3c_par_data", 32'(dout0), 32'h3C);
    chk("3c_par_perr", 32'(pe0),   32'h1);
    chk("3c_par_ferr", 32'(fe0),   32'h0);
    ack_pulse(0);

    // Framing error on 0x3C
    send(0, mkf(9'h03C, 8, 1, 1'b0, 1'b0, 1'b1), 11, 16, -1, -1, 9999);
    chk("3c_stop_data", 32'(dout0), 32'h3C);
    chk("3c_stop_ferr", 32'(fe0),   32'h1);
    chk("3c_stop_perr", 32'(pe0),   32'h0);
    ack_pulse(0);

    // Short low glitch is rejected, next frame still received
    ser0 = 1'b0;
    repeat (4) @(negedge clk);
    ser0 = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_valid", 32'(v0), 32'h0);
    send(0, mkf(9'h055, 8, 1, 1'b0, 1'b1, 1'b1), 11, 16, -1, -1, 9999);
    chk("55_data",  32'(dout0), 32'h55);
    chk("55_valid", 32'(v0),    32'h1);
    chk("55_ferr",  32'(fe0),   32'h0);
    ack_pulse(0);

    // Back-to-back without ack: second frame dropped, overrun set
    send(0, mkf(9'h011, 8, 1, 1'b0, 1'b1, 1'b1), 11, 16, -1, -1, 9999);
    send(0, mkf(9'h022, 8, 1, 1'b0, 1'b1, 1'b1), 11, 16, -1, -1, 9999);
    chk("b2b_data",  32'(dout0), 32'h11);
    chk("b2b_ovr",   32'(ov0),   32'h1);
    chk("b2b_valid", 32'(v0),    32'h1);
    ack_pulse(0);
    chk("b2b_ack_valid", 32'(v0), 32'h0);
    chk("b2b_ack_ovr",   32'(ov0), 32'h0);

    // Back-to-back with ack on the second commit tick
    send(0, mkf(9'h011, 8, 1, 1'b0, 1'b1, 1'b1), 11, 16, -1, -1, 9999);
    send(0, mkf(9'h022, 8, 1, 1'b0, 1'b1, 1'b1), 11, 16, 170, -1, 9999);
    chk("ackc_data",  32'(dout0), 32'h22);
    chk("ackc_ovr",   32'(ov0),   32'h0);
    chk("ackc_valid", 32'(v0),    32'h1);

    // Erroneous frame arriving while a word is held is discarded
    send(0, mkf(9'h03C, 8, 1, 1'b1, 1'b0, 1'b1), 11, 16, -1, -1, 9999);
    chk("drop_data", 32'(dout0), 32'h22);
    chk("drop_ovr",  32'(ov0),   32'h1);
    chk("drop_perr", 32'(pe0),   32'h0);
    chk("drop_ferr", 32'(fe0),   32'h0);

    // Reset in the middle of the data bits of 0xFF
    send(0, mkf(9'h0FF, 8, 1, 1'b0, 1'b1, 1'b1), 11, 16, -1, 60, 61);
    chk("mrst_data",  32'(dout0), 32'h0);
    chk("mrst_valid", 32'(v0),    32'h0);
    chk("mrst_ovr",   32'(ov0),   32'h0);
    chk("mrst_perr",  32'(pe0),   32'h0);
    chk("mrst_ferr",  32'(fe0),   32'h0);
    send(0, mkf(9'h081, 8, 1, 1'b0, 1'b1, 1'b1), 11, 16, -1, -1, 9999);
    chk("81_data",  32'(dout0), 32'h81);
    chk("81_valid", 32'(v0),    32'h1);
    chk("81_perr",  32'(pe0),   32'h0);
    ack_pulse(0);

    // Line held low for two frame times
    ser0 = 1'b0;
    repeat (352) @(negedge clk);
    ser0 = 1'b1;
    repeat (24) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
    chk("brk_pulses", 32'(n_brk0), 32'd1);
    chk("brk_valid",  32'(v0),     32'h0);
    chk("brk_data",   32'(dout0),  32'h81);
    send(0, mkf(9'h0A5, 8, 1, 1'b0, 1'b1, 1'b1), 11, 16, -1, -1, 9999);
    chk("brk_rec_data",  32'(dout0), 32'hA5);
    chk("brk_rec_valid", 32'(v0),    32'h1);
`else
    chk("brk_data",   32'(dout0),  32'h00);
    chk("brk_ferr",   32'(fe0),    32'h1);
    chk("brk_perr",   32'(pe0),    32'h0);
    chk("brk_valid",  32'(v0),     32'h1);
    chk("brk_pulses", 32'(n_brk0), 32'd0);
`endif
    ack_pulse(0);

    // Second configuration: 7 data bits, odd parity, two stops, x8
    send(1, mkf(9'h041, 7, 1, 1'b1, 1'b1, 1'b1), 11, 8, -1, -1, 9999);
    chk("s41_data",  32'(dout1), 32'h41);
    chk("s41_perr",  32'(pe1),   32'h0);
    chk("s41_ferr",  32'(fe1),   32'h0);
    chk("s41_valid", 32'(v1),    32'h1);
    ack_pulse(1);
    chk("s41_ack_valid", 32'(v1), 32'h0);

    send(1, mkf(9'h041, 7, 1, 1'b1, 1'b1, 1'b0), 11, 8, -1, -1, 9999);
    chk("s41_stop2_data", 32'(dout1), 32'h41);
    chk("s41_stop2_ferr", 32'(fe1),   32'h1);
    chk("s41_stop2_perr", 32'(pe1),   32'h0);
    ack_pulse(1);

    send(1, mkf(9'h041, 7, 1, 1'b0, 1'b1, 1'b1), 11, 8, -1, -1, 9999);
    chk("s41_par_perr", 32'(pe1), 32'h1);
    chk("s41_par_ferr", 32'(fe1), 32'h0);
    ack_pulse(1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised, oversampling UART receiver; next generation of the fixed 8-data + parity receiver FSM.
- Configurable data width, parity mode, stop-bit count and oversample ratio.
- Adds input synchronisation, false-start rejection, majority-vote sampling, parity/framing/overrun error flags and a valid/ack handshake.
- Sits between the baud-rate generator (supplies baudOut) and the consumer/FIFO.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9), LSB first
- PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, stop bits checked (1 or 2)
- OVERSAMPLE, 16, baudOut ticks per bit (even, >= 8)

Ports:
- baudOut  input  1  clock; rate = OVERSAMPLE x bit rate
- rst  input  1  synchronous, active-high reset
- serialInput  input  1  asynchronous serial line, idle high
- rxAck  input  1  consumer accepts the held word
- dataOut  output  DATA_BITS  last received word
- parityError  output  1  parity mismatch for dataOut (0 when PARITY_MODE = 0)
- framingError  output  1  a stop bit sampled 0 for dataOut
- rxValid  output  1  dataOut holds an unacknowledged word
- overrun  output  1  sticky; a frame was dropped while rxValid = 1
- breakDetected  output  1  one-cycle pulse on line break

Behaviour:
- Reset (rst = 1 at posedge baudOut):
  - state = IDLE, counter = 0, bit index = 0.
  - Synchroniser flops and 3-sample history = 1.
  - All outputs = 0.
  - Reset mid-frame aborts the frame; no commit.
- Synchroniser: 2 flops, then a 3-deep history shift register. Sample value = majority of the 3 history bits.
- Falling-edge detect uses the synchronised value (previous 1, current 0).
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - Falling edge -> START, counter = 0.
- START:
  - Counter increments each tick.
  - At counter = OVERSAMPLE/2-1: sample = 1 -> IDLE (false start, no flags); sample = 0 -> DATA, counter = 0.
- DATA:
  - At counter = OVERSAMPLE-1 (mid-bit): shift sample in LSB first, counter = 0, bit index++.
  - After DATA_BITS bits -> PARITY, or STOP if PARITY_MODE = 0.
- PARITY:
  - One bit, sampled at mid-bit.
  - Even mode: error if XOR(data, parity) = 1.
  - Odd mode: error if XOR(data, parity) = 0.
- STOP:
  - Each stop bit is sampled at mid-bit; any 0 sets the framing flag.
  - Commit occurs on the tick the last stop bit is sampled; FSM -> IDLE the same tick, so a back-to-back start edge is caught.
- Commit (registered, visible next tick):
  - rxValid = 0, or rxAck = 1 that tick: load dataOut, parityError, framingError; rxValid = 1.
  - rxValid = 1 and rxAck = 0: frame discarded; dataOut and flags unchanged; overrun = 1.
- rxAck:
  - rxAck with rxValid = 1 and no commit that tick -> rxValid = 0 and overrun = 0 next tick.
  - rxAck with rxValid = 0 -> ignored.
- Latency: start edge on pin to rxValid = 2 + OVERSAMPLE/2 + (DATA_BITS + P + STOP_BITS)*OVERSAMPLE + 1 ticks, where P = 1 if parity is enabled, else 0. Majority vote adds 1 tick of skew.
- Width rules: counter is clog2(OVERSAMPLE) bits; bit index is clog2(DATA_BITS+1) bits.
- The BREAK state is used only with the optional feature.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined:
  - A frame with all data bits, the parity bit (if any) and the first stop bit sampled 0 is a break.
  - No commit; rxValid, dataOut and the flags are unchanged.
  - breakDetected pulses for 1 tick; FSM -> BREAK.
  - BREAK exits to IDLE only after the synchronised line has been 1 for OVERSAMPLE consecutive ticks.
- Undefined:
  - A break is committed as data 0 with framingError = 1, then normal IDLE.
  - breakDetected is tied 0; the BREAK state is not built.

Test Plan:
- Reference configuration: DATA_BITS = 8, even parity, 1 stop, OVERSAMPLE = 16.
- Frame 0xA5, parity 0, stop 1 -> dataOut = 0xA5, parityError = 0, framingError = 0, rxValid = 1; rxAck -> rxValid = 0 next tick.
- Frame 0x3C with parity bit 1 -> dataOut = 0x3C, parityError = 1. Frame 0x3C with stop bit 0 -> framingError = 1.
- Low glitch of 4 ticks on an idle line -> no state leaves IDLE beyond START; rxValid stays 0; next valid frame 0x55 received correctly.
- Two back-to-back frames 0x11, 0x22, no rxAck -> dataOut = 0x11, overrun = 1. Then rxAck -> rxValid = 0, overrun = 0. Repeat with rxAck on the commit tick -> dataOut = 0x22, overrun = 0.
- rst asserted for 1 tick mid-DATA of frame 0xFF -> all outputs 0, no commit. Subsequent frame 0x81 received correctly.
- Line held 0 for 2 frame times:
  - With macro: breakDetected pulses once, rxValid = 0; recovery only after 16 idle ticks.
  - Without macro: dataOut = 0x00, framingError = 1.
- Parameter sweep: DATA_BITS = 7, odd parity, 2 stops, OVERSAMPLE = 8, frame 0x41 -> dataOut = 0x41, no errors. Second stop bit 0 -> framingError = 1.
